ddr_cal_reset_sequencer: RTL and testbench
==========================================

DDR_CAL_RESET_SEQUENCER -- requirements
Module: ddr_cal_reset_sequencer

Interface
REQ-001: Parameter RESET_PULSE_CYCLES, default 16, is the number of cycles mem_soft_reset_n is held low per memory-controller reset attempt (range 1..255).
REQ-002: Parameter TIMEOUT_CYCLES, default 50000000, is the WAIT_CAL calibration timeout in cycles (1 s at 50 MHz; range 2..2^26).
REQ-003: Parameter SETTLE_CYCLES, default 1024, is the number of stable-good cycles required before kernel release (range 1..65535).
REQ-004: Parameter MAX_RETRIES, default 3, is the number of re-attempts allowed after the first attempt (range 0..15).
REQ-005: clk_50_clk  in  1  single clock for all logic.
REQ-006: reset_50_reset  in  1  reset; one clock, reset synchronous and active-high.
REQ-007: fpga_sdram_status_local_init_done  in  1  asynchronous controller init-done status.
REQ-008: fpga_sdram_status_local_cal_success  in  1  asynchronous calibration-success status.
REQ-009: fpga_sdram_status_local_cal_fail  in  1  asynchronous calibration-fail status.
REQ-010: mem_soft_reset_n  out  1  active-low reset to the FPGA DDR3 controller.
REQ-011: kernel_reset_n  out  1  active-low reset to the kernel clock domain consumers.
REQ-012: ready  out  1  memory calibrated and kernel released.
REQ-013: fail  out  1  sticky fatal failure; all retries exhausted.
REQ-014: retry_count  out  4  retries consumed so far.
REQ-015: state  out  3  current state encoding: RST_MEM=0, WAIT_CAL=1, SETTLE=2, READY=3, FAIL=4.

Function
REQ-016: Each status input SHALL pass through a 2-flop synchronizer (reset to 0); all decisions use synced values (_s), giving 2 cycles input-to-decision latency.
REQ-017: All outputs SHALL be registered; outputs are decoded from the state register and change in the same cycle as state.
REQ-018: RST_MEM: mem_soft_reset_n=0, kernel_reset_n=0; pulse counter increments; after RESET_PULSE_CYCLES cycles in RST_MEM, go to WAIT_CAL and clear the timeout counter.
REQ-019: WAIT_CAL: mem_soft_reset_n=1, kernel_reset_n=0; timeout counter increments each cycle.
REQ-020: WAIT_CAL priority: cal_fail_s -> RETRY decision; else init_done_s && cal_success_s -> SETTLE (clear settle counter); else counter == TIMEOUT_CYCLES-1 -> RETRY decision.
REQ-021: cal_fail_s asserted together with cal_success_s SHALL be treated as failure.
REQ-022: SETTLE: kernel_reset_n=0; settle counter increments while init_done_s && cal_success_s && !cal_fail_s; any violation -> RETRY decision; counter == SETTLE_CYCLES-1 with condition still good -> READY.
REQ-023: READY: kernel_reset_n=1, ready=1; any of !init_done_s, !cal_success_s, cal_fail_s -> RETRY decision (kernel_reset_n and ready drop in the next cycle).
REQ-024: RETRY decision (not a state; evaluated in the transition cycle): if retry_count < MAX_RETRIES, increment retry_count and go to RST_MEM (clear pulse counter); otherwise go to FAIL without incrementing.
REQ-025: FAIL: fail=1, ready=0, kernel_reset_n=0, mem_soft_reset_n=1; FAIL SHALL be terminal until reset_50_reset.
REQ-026: retry_count SHALL never exceed MAX_RETRIES and SHALL NOT clear on reaching READY; only reset clears it.
REQ-027: With MAX_RETRIES=0, the first failure SHALL go directly to FAIL.
REQ-028: Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap; each is cleared on entry to its state.

Reset
REQ-029: While reset_50_reset=1 at a clock edge: state=RST_MEM, mem_soft_reset_n=0, kernel_reset_n=0, ready=0, fail=0, retry_count=0, all counters and synchronizer flops 0.
REQ-030: Reset asserted mid-operation (any state, including FAIL) SHALL take effect at the next edge and restart the full sequence with no residual retry count.
REQ-031: The first cycle after reset deassertion SHALL count as RST_MEM cycle 1, so mem_soft_reset_n stays low exactly RESET_PULSE_CYCLES cycles after release.

Verification (RESET_PULSE_CYCLES=4, TIMEOUT_CYCLES=100, SETTLE_CYCLES=8, MAX_RETRIES=2)
REQ-032: Happy path: init_done and cal_success go high at cycle 10 after reset -> mem_soft_reset_n high at cycle 4; SETTLE entered at cycle 12; ready=1, kernel_reset_n=1 at cycle 20; retry_count=0.
REQ-033: Timeout: statuses held low -> three 4-cycle mem_soft_reset_n pulses; retry_count sequence 1, 2; fail=1, state=4 after the third timeout; state remains 4 for 1000 further cycles.
REQ-034: cal_fail pulse of 3 cycles in WAIT_CAL with cal_success=1 -> RETRY taken, not SETTLE; retry_count=1.
REQ-035: Glitch: cal_success drops for 1 cycle at SETTLE cycle 5 -> retry_count=1, RST_MEM re-entered, and ready never asserts during that attempt.
REQ-036: READY loss: init_done drops in READY -> kernel_reset_n=0 and ready=0 within 3 cycles of the input edge; retry_count increments.
REQ-037: Reset asserted in FAIL and in READY -> next-cycle outputs match REQ-029, and the happy-path sequence then repeats with identical timing.

Source files
------------

// File: rtl/ddr_cal_reset_sequencer.sv
// DDR3 calibration reset sequencer: pulses the memory controller reset, waits for
// calibration, requires a stable-good settle window, then releases the kernel reset.
module ddr_cal_reset_sequencer #(
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES     = 50000000,
    parameter int SETTLE_CYCLES      = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       clk_50_clk,
    input  logic       reset_50_reset,
    input  logic       fpga_sdram_status_local_init_done,
    input  logic       fpga_sdram_status_local_cal_success,
    input  logic       fpga_sdram_status_local_cal_fail,
    output logic       mem_soft_reset_n,
    output logic       kernel_reset_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    localparam int PULSE_W   = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [PULSE_W-1:0]   PULSE_LAST   = PULSE_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]           RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST_MEM  = 3'd0,
        ST_WAIT_CAL = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_READY    = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    state_t               state_r, state_next;
    logic [PULSE_W-1:0]   pulse_cnt_r, pulse_cnt_next;
    logic [TIMEOUT_W-1:0] timeout_cnt_r, timeout_cnt_next;
    logic [SETTLE_W-1:0]  settle_cnt_r, settle_cnt_next;
    logic [3:0]           retry_cnt_r, retry_cnt_next;
    logic [2:0]           sync1_r, sync2_r;
    logic                 init_done_s, cal_success_s, cal_fail_s, status_good_s;
    logic                 retry_req_s;

    assign init_done_s   = sync2_r[0];
    assign cal_success_s = sync2_r[1];
    assign cal_fail_s    = sync2_r[2];
    // A simultaneous fail and success is treated as a failure.
    assign status_good_s = init_done_s && cal_success_s && !cal_fail_s;

    assign retry_count = retry_cnt_r;
    assign state       = state_r;

    // Two-flop synchronizers for the asynchronous controller status inputs.
    always_ff @(posedge clk_50_clk) begin
        if (reset_50_reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= {fpga_sdram_status_local_cal_fail,
                        fpga_sdram_status_local_cal_success,
                        fpga_sdram_status_local_init_done};
            sync2_r <= sync1_r;
        end
    end

    // Next-state, counter and retry decision logic.
    always_comb begin
        state_next       = state_r;
        pulse_cnt_next   = pulse_cnt_r;
        timeout_cnt_next = timeout_cnt_r;
        settle_cnt_next  = settle_cnt_r;
        retry_cnt_next   = retry_cnt_r;
        retry_req_s      = 1'b0;
        case (state_r)
            ST_RST_MEM: begin
                if (pulse_cnt_r == PULSE_LAST) begin
                    state_next       = ST_WAIT_CAL;
                    timeout_cnt_next = '0;
                end else begin
                    pulse_cnt_next = pulse_cnt_r + PULSE_W'(1);
                end
            end
            ST_WAIT_CAL: begin
                if (cal_fail_s) begin
                    retry_req_s = 1'b1;
                end else if (init_done_s && cal_success_s) begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = '0;
                end else if (timeout_cnt_r == TIMEOUT_LAST) begin
                    retry_req_s = 1'b1;
                end else begin
                    timeout_cnt_next = timeout_cnt_r + TIMEOUT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!status_good_s) begin
                    retry_req_s = 1'b1;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_next = ST_READY;
                end else begin
                    settle_cnt_next = settle_cnt_r + SETTLE_W'(1);
                end
            end
            ST_READY: begin
                if (!status_good_s) begin
                    retry_req_s = 1'b1;
                end else begin
                    state_next = ST_READY;
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next     = ST_RST_MEM;
                pulse_cnt_next = '0;
            end
        endcase

        if (retry_req_s) begin
            if (retry_cnt_r < RETRY_MAX) begin
                retry_cnt_next = retry_cnt_r + 4'd1;
                state_next     = ST_RST_MEM;
                pulse_cnt_next = '0;
            end else begin
                state_next = ST_FAIL;
            end
        end else begin
            retry_cnt_next = retry_cnt_r;
        end
    end

    // State, counters and outputs; outputs are decoded from the next state so they
    // move in the same cycle as the state register.
    always_ff @(posedge clk_50_clk) begin
        if (reset_50_reset) begin
            state_r          <= ST_RST_MEM;
            pulse_cnt_r      <= '0;
            timeout_cnt_r    <= '0;
            settle_cnt_r     <= '0;
            retry_cnt_r      <= 4'd0;
            mem_soft_reset_n <= 1'b0;
            kernel_reset_n   <= 1'b0;
            ready            <= 1'b0;
            fail             <= 1'b0;
        end else begin
            state_r          <= state_next;
            pulse_cnt_r      <= pulse_cnt_next;
            timeout_cnt_r    <= timeout_cnt_next;
            settle_cnt_r     <= settle_cnt_next;
            retry_cnt_r      <= retry_cnt_next;
            mem_soft_reset_n <= (state_next != ST_RST_MEM);
            kernel_reset_n   <= (state_next == ST_READY);
            ready            <= (state_next == ST_READY);
            fail             <= (state_next == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_ddr_cal_reset_sequencer.sv
// Directed bench for ddr_cal_reset_sequencer with small timing parameters.
// Cycle k is the interval starting at the k-th edge after the last reset edge.
module tb_ddr_cal_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done, cal_success, cal_fail;
    logic       mem_soft_reset_n, kernel_reset_n, ready, fail;
    logic [3:0] retry_count;
    logic [2:0] state;

    int cyc;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ddr_cal_reset_sequencer #(
        .RESET_PULSE_CYCLES (4),
        .TIMEOUT_CYCLES     (100),
        .SETTLE_CYCLES      (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clk_50_clk                          (clk),
        .reset_50_reset                      (rst),
        .fpga_sdram_status_local_init_done   (init_done),
        .fpga_sdram_status_local_cal_success (cal_success),
        .fpga_sdram_status_local_cal_fail    (cal_fail),
        .mem_soft_reset_n                    (mem_soft_reset_n),
        .kernel_reset_n                      (kernel_reset_n),
        .ready                               (ready),
        .fail                                (fail),
        .retry_count                         (retry_count),
        .state                               (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    // One reset edge, check the reset values, then release; cycle 0 starts now.
    task automatic apply_reset(input string tg);
        rst = 1'b1;
        init_done = 1'b0;
        cal_success = 1'b0;
        cal_fail = 1'b0;
        step();
        check({tg, "_state"}, 32'(state), 32'd0);
        check({tg, "_mem_n"}, 32'(mem_soft_reset_n), 32'd0);
        check({tg, "_kern_n"}, 32'(kernel_reset_n), 32'd0);
        check({tg, "_ready"}, 32'(ready), 32'd0);
        check({tg, "_fail"}, 32'(fail), 32'd0);
        check({tg, "_retry"}, 32'(retry_count), 32'd0);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Statuses sampled good from the edge of cycle 10 onwards.
    task automatic happy(input string tg);
        check({tg, "_mem_c0"}, 32'(mem_soft_reset_n), 32'd0);
        run_to(3);
        check({tg, "_mem_c3"}, 32'(mem_soft_reset_n), 32'd0);
        run_to(4);
        check({tg, "_mem_c4"}, 32'(mem_soft_reset_n), 32'd1);
        check({tg, "_st_c4"}, 32'(state), 32'd1);
        run_to(9);
        init_done = 1'b1;
        cal_success = 1'b1;
        run_to(11);
        check({tg, "_st_c11"}, 32'(state), 32'd1);
        run_to(12);
        check({tg, "_st_c12"}, 32'(state), 32'd2);
        run_to(19);
        check({tg, "_rdy_c19"}, 32'(ready), 32'd0);
        check({tg, "_kern_c19"}, 32'(kernel_reset_n), 32'd0);
        run_to(20);
        check({tg, "_rdy_c20"}, 32'(ready), 32'd1);
        check({tg, "_kern_c20"}, 32'(kernel_reset_n), 32'd1);
        check({tg, "_st_c20"}, 32'(state), 32'd3);
        check({tg, "_retry_c20"}, 32'(retry_count), 32'd0);
    endtask

    initial begin
        int low;
        int bad;
        int rdy_seen;
        cyc = 0;
        rst = 1'b1;
        init_done = 1'b0;
        cal_success = 1'b0;
        cal_fail = 1'b0;
        step();

        apply_reset("por");
        happy("happy1");

        // Lose init_done in READY; sampled at edge 25, state changes at cycle 27.
        run_to(24);
        init_done = 1'b0;
        run_to(26);
        check("loss_rdy_c26", 32'(ready), 32'd1);
        run_to(27);
        check("loss_rdy_c27", 32'(ready), 32'd0);
        check("loss_kern_c27", 32'(kernel_reset_n), 32'd0);
        check("loss_st_c27", 32'(state), 32'd0);
        check("loss_retry_c27", 32'(retry_count), 32'd1);
        init_done = 1'b1;
        run_to(40);
        check("recover_st_c40", 32'(state), 32'd3);
        check("recover_retry_kept", 32'(retry_count), 32'd1);

        apply_reset("rst_in_ready");
        happy("happy2");

        // Statuses held low: three timeouts, then terminal FAIL.
        apply_reset("rst_to");
        low = 0;
        while (cyc < 312) begin
            if (mem_soft_reset_n == 1'b0) low++;
            if (cyc == 103) check("to_st_c103", 32'(state), 32'd1);
            if (cyc == 104) check("to_retry_c104", 32'(retry_count), 32'd1);
            if (cyc == 104) check("to_st_c104", 32'(state), 32'd0);
            if (cyc == 108) check("to_st_c108", 32'(state), 32'd1);
            if (cyc == 208) check("to_retry_c208", 32'(retry_count), 32'd2);
            if (cyc == 311) check("to_st_c311", 32'(state), 32'd1);
            step();
        end
        check("to_low_cycles", 32'(low), 32'd12);
        check("to_fail", 32'(fail), 32'd1);
        check("to_state", 32'(state), 32'd4);
        check("to_retry_final", 32'(retry_count), 32'd2);
        check("to_mem_n_fail", 32'(mem_soft_reset_n), 32'd1);
        check("to_kern_fail", 32'(kernel_reset_n), 32'd0);
        check("to_ready_fail", 32'(ready), 32'd0);
        init_done = 1'b1;
        cal_success = 1'b1;
        bad = 0;
        repeat (1000) begin
            step();
            if (state != 3'd4 || fail != 1'b1) bad++;
        end
        check("fail_terminal", 32'(bad), 32'd0);

        apply_reset("rst_in_fail");
        happy("happy3");

        // cal_fail with cal_success sampled at edges 6..8: retry, never SETTLE.
        apply_reset("rst_cf");
        run_to(5);
        init_done = 1'b1;
        cal_success = 1'b1;
        cal_fail = 1'b1;
        run_to(7);
        check("cf_st_c7", 32'(state), 32'd1);
        run_to(8);
        cal_fail = 1'b0;
        check("cf_st_c8", 32'(state), 32'd0);
        check("cf_retry", 32'(retry_count), 32'd1);

        // cal_success dropped for one sampled cycle at SETTLE cycle 5.
        apply_reset("rst_gl");
        init_done = 1'b0;
        run_to(9);
        init_done = 1'b1;
        cal_success = 1'b1;
        run_to(12);
        check("gl_st_c12", 32'(state), 32'd2);
        rdy_seen = 0;
        while (cyc < 18) begin
            if (cyc == 15) cal_success = 1'b0;
            if (cyc == 16) cal_success = 1'b1;
            if (cyc == 17) check("gl_st_c17", 32'(state), 32'd2);
            step();
            if (ready == 1'b1) rdy_seen++;
        end
        check("gl_st_c18", 32'(state), 32'd0);
        check("gl_retry", 32'(retry_count), 32'd1);
        check("gl_no_ready", 32'(rdy_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
